axil_resp_ram: RTL and testbench
================================

// Module: axil_resp_ram
// PURPOSE
//  AXI4-Lite responder (slave) for the picorv32_axi bench/SoC: word-addressed RAM plus console and test-pass
//  registers. It answers the CPU's initiator traffic, with independent AW/W/B and AR/R channels and one
//  outstanding transaction per direction. An optional stall injector randomises ready/valid timing to
//  stress the initiator's handshake logic.
// PARAMETERS
//  MEM_WORDS    4096           RAM depth in 32-bit words; power of 2; RAM at byte addr 0 .. MEM_WORDS*4-1
//  CONSOLE_ADDR 32'h1000_0000  write-only console byte register
//  PASS_ADDR    32'h2000_0000  write-only test-pass register
//  PASS_MAGIC   32'd123456789  value that sets tests_passed
//  LFSR_SEED    16'hACE1       stall LFSR reset value; nonzero; used only with AXIL_STALL_EN
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, synchronous, active-low
//  awvalid/awready in/out 1  write address handshake;  awaddr in 32;  awprot in 3 (ignored)
//  wvalid/wready  in/out 1   write data handshake;  wdata in 32;  wstrb in 4 (byte enables)
//  bvalid/bready  out/in 1   write response handshake;  bresp out 2
//  arvalid/arready in/out 1  read address handshake;  araddr in 32;  arprot in 3 (ignored)
//  rvalid/rready  out/in 1   read data handshake;  rdata out 32;  rresp out 2
//  console_valid  out  1   one-cycle pulse on accepted console write
//  console_data   out  8   wdata[7:0] of that write; valid with console_valid
//  tests_passed   out  1   sticky; set by PASS_MAGIC written to PASS_ADDR
//  err_decode     out  1   one-cycle pulse on any access to an unmapped address
// BEHAVIOUR
//  Reset (resetn low at posedge): bvalid, rvalid, console_valid, err_decode, tests_passed, aw_held, w_held,
//   wr_fire = 0; bresp, rresp, rdata = 0. awready/wready/arready forced 0 while resetn low. RAM not cleared.
//   Reset mid-transaction drops all held/pending state; no response is issued for it.
//  Write path:
//   - awready = !aw_held; wready = !w_held. AW and W accepted independently, in either order or the same
//     cycle; each latched into its holding register (aw_held / w_held set).
//   - Cycle after both held: commit. RAM bytes written per wstrb; holding regs cleared; bvalid=1.
//     Min latency: AW+W handshake in cycle N -> commit at N+1, bvalid seen from N+1.
//   - bvalid and bresp held stable until bready. A new AW/W is accepted while bvalid=1, but the next
//     commit waits for the B handshake (max one response pending).
//  Read path:
//   - arready = !rvalid. AR handshake in cycle N -> rdata/rresp registered, rvalid=1 from N+1.
//   - Both held stable until rready; back-to-back reads give one read per 2 cycles at most.
//  Decode (word address = addr[31:2]; addr[1:0] ignored):
//   - RAM: addr < MEM_WORDS*4. resp=OKAY (2'b00).
//   - CONSOLE_ADDR write: console_valid pulses at commit if wstrb[0]=1; resp OKAY. Read -> rdata 0, OKAY.
//   - PASS_ADDR write: if wdata==PASS_MAGIC (wstrb ignored) set tests_passed; otherwise no effect; OKAY.
//     Read -> rdata {31'b0,tests_passed}, OKAY.
//   - Anything else: write dropped; read rdata=32'hDEADBEEF; resp DECERR (2'b11); err_decode pulses at
//     commit (write) or at the AR handshake (read); both the same cycle is still a single pulse.
//  Write commit and AR handshake in the same cycle to the same RAM word: the read returns pre-write data.
// CONFIGURATION
//  AXIL_STALL_EN defined: a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed LFSR_SEED) steps every cycle.
//   awready/wready/arready are additionally ANDed with lfsr[0]/lfsr[1]/lfsr[2].
//   bvalid/rvalid assertion is delayed by lfsr[4:3] (0-3) extra cycles.
//   All other rules (stability, ordering, single outstanding) unchanged.
//  AXIL_STALL_EN undefined: no LFSR; minimum latencies as stated above.
// TESTING
//  1 Reset: resetn low 4 cycles -> all readies 0, bvalid/rvalid 0, tests_passed 0; first cycle after release
//    awready=wready=arready=1.
//  2 AW(0x10) at N, W(0xA5A5_5A5A, strb 4'hF) at N+2 -> bvalid at N+3 bresp 0.
//    Then read 0x10 -> rdata 0xA5A55A5A rresp 0.
//  3 Partial write 0x10 with wdata 0x1122_3344, strb 4'b0101, over 0xA5A55A5A -> read returns 0xA522_5A44.
//  4 Hold bready=0 for 5 cycles after bvalid -> bvalid/bresp stable. A 2nd AW+W accepted but bvalid
//    re-asserts only after the first B handshake.
//  5 Write 'H'(0x48) to CONSOLE_ADDR -> one console_valid pulse, data 0x48. Write 123456789 to PASS_ADDR
//    -> tests_passed=1 and stays 1. Write 5 there afterwards -> still 1.
//  6 Read 0x3000_0000 -> rdata 0xDEADBEEF, rresp 2'b11, one err_decode pulse. Rerun 2-5 with AXIL_STALL_EN
//    -> same data results, no handshake-stability violation.

Source files
------------

// File: rtl/axil_resp_ram.sv
// axil_resp_ram: AXI4-Lite responder with word RAM, console and test-pass registers.
// Optional define AXIL_STALL_EN adds LFSR-driven ready/valid stall injection.
module axil_resp_ram #(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_MAGIC   = 32'd123456789,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        tests_passed,
    output logic        err_decode
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    logic        aw_held, w_held;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
    logic aw_gate, w_gate, ar_gate;
    logic commit, rd_busy, rv_set;
    logic [31:0] cm_addr, cm_data;
    logic [3:0]  cm_strb;
    logic cm_ram, cm_con, cm_pass, cm_bad;
    logic ar_ram, ar_con, ar_pass, ar_bad;
    logic unused_bits;

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign ar_fire = arvalid & arready;
    assign b_fire  = bvalid & bready;
    assign r_fire  = rvalid & rready;

    assign awready = resetn & ~aw_held & aw_gate;
    assign wready  = resetn & ~w_held & w_gate;
    assign arready = resetn & ~rvalid & ~rd_busy & ar_gate;

`ifdef AXIL_STALL_EN
    logic [15:0] lfsr;
    logic        wr_arm, rd_pend;
    logic [1:0]  wr_cnt, rd_cnt;

    // Galois LFSR x^16+x^14+x^13+x^11+1, one step per cycle
    always_ff @(posedge clk) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign aw_gate = lfsr[0];
    assign w_gate  = lfsr[1];
    assign ar_gate = lfsr[2];

    // Writes commit only from the holding registers, after a random wait
    assign commit  = resetn & wr_arm & (wr_cnt == 2'd0);
    assign cm_addr = aw_addr_q;
    assign cm_data = w_data_q;
    assign cm_strb = w_strb_q;
    assign rd_busy = rd_pend;
    assign rv_set  = rd_pend & (rd_cnt == 2'd0);

    // Random extra delay before B and R responses become visible
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_arm  <= 1'b0;
            wr_cnt  <= 2'd0;
            rd_pend <= 1'b0;
            rd_cnt  <= 2'd0;
        end else begin
            if (commit) begin
                wr_arm <= 1'b0;
            end else if (wr_arm) begin
                wr_cnt <= wr_cnt - 2'd1;
            end else if (aw_held && w_held && !bvalid) begin
                wr_arm <= 1'b1;
                wr_cnt <= lfsr[4:3];
            end
            if (ar_fire) begin
                rd_pend <= 1'b1;
                rd_cnt  <= lfsr[4:3];
            end else if (rd_pend && rd_cnt != 2'd0) begin
                rd_cnt <= rd_cnt - 2'd1;
            end else if (rd_pend) begin
                rd_pend <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{awprot, arprot, cm_addr[1:0], araddr[1:0]};
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign ar_gate = 1'b1;

    // A handshake in flight counts as held, so AW+W together commit at once
    assign commit  = resetn & (aw_held | aw_fire) & (w_held | w_fire) & ~bvalid;
    assign cm_addr = aw_held ? aw_addr_q : awaddr;
    assign cm_data = w_held ? w_data_q : wdata;
    assign cm_strb = w_held ? w_strb_q : wstrb;
    assign rd_busy = 1'b0;
    assign rv_set  = ar_fire;

    assign unused_bits = ^{awprot, arprot, cm_addr[1:0], araddr[1:0], LFSR_SEED};
`endif

    assign cm_ram  = (cm_addr[31:AW+2] == '0);
    assign cm_con  = (cm_addr[31:2] == CONSOLE_ADDR[31:2]);
    assign cm_pass = (cm_addr[31:2] == PASS_ADDR[31:2]);
    assign cm_bad  = ~(cm_ram | cm_con | cm_pass);

    assign ar_ram  = (araddr[31:AW+2] == '0);
    assign ar_con  = (araddr[31:2] == CONSOLE_ADDR[31:2]);
    assign ar_pass = (araddr[31:2] == PASS_ADDR[31:2]);
    assign ar_bad  = ~(ar_ram | ar_con | ar_pass);

    // RAM byte-lane writes on commit; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && cm_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) mem[cm_addr[AW+1:2]][8*b +: 8] <= cm_data[8*b +: 8];
            end
        end
    end

    // Holding registers, B/R responses and side-band pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            bvalid        <= 1'b0;
            bresp         <= 2'b00;
            rvalid        <= 1'b0;
            rdata         <= '0;
            rresp         <= 2'b00;
            console_valid <= 1'b0;
            console_data  <= '0;
            tests_passed  <= 1'b0;
            err_decode    <= 1'b0;
        end else begin
            if (aw_fire) aw_addr_q <= awaddr;
            if (w_fire) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            aw_held <= ~commit & (aw_held | aw_fire);
            w_held  <= ~commit & (w_held | w_fire);

            console_valid <= 1'b0;
            if (b_fire) bvalid <= 1'b0;
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= cm_bad ? 2'b11 : 2'b00;
                if (cm_con && cm_strb[0]) begin
                    console_valid <= 1'b1;
                    console_data  <= cm_data[7:0];
                end
                if (cm_pass && cm_data == PASS_MAGIC) tests_passed <= 1'b1;
            end
            err_decode <= (commit & cm_bad) | (ar_fire & ar_bad);

            if (r_fire) rvalid <= 1'b0;
            if (rv_set) rvalid <= 1'b1;
            if (ar_fire) begin
                rresp <= ar_bad ? 2'b11 : 2'b00;
                if (ar_ram) rdata <= mem[araddr[AW+1:2]];
                else if (ar_pass) rdata <= {31'b0, tests_passed};
                else if (ar_con) rdata <= '0;
                else rdata <= 32'hDEADBEEF;
            end
        end
    end
endmodule

// File: tb/tb_axil_resp_ram.sv
// tb_axil_resp_ram: randomized scoreboard bench for axil_resp_ram.
// Expected B/R/console results are queued at issue and popped by a monitor.
module tb_axil_resp_ram;
    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        console_valid, tests_passed, err_decode;
    logic [7:0]  console_data;

    always #5 clk = ~clk;

    axil_resp_ram dut (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .console_valid(console_valid), .console_data(console_data),
        .tests_passed(tests_passed), .err_decode(err_decode)
    );

    int n_vec = 0;
    int n_bad = 0;
    int b_issued = 0;
    int b_done = 0;
    int err_exp = 0;
    int err_seen = 0;
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [7:0]  con_q[$];
    logic [31:0] ref_mem[int];
    logic        ref_pass = 1'b0;
    logic        b_hold = 1'b0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait expired, expected DUT event", name);
    endtask

    // 0 = RAM, 1 = console, 2 = pass, 3 = unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'h0000_4000) return 0;
        if ((a & 32'hFFFF_FFFC) == 32'h1000_0000) return 1;
        if ((a & 32'hFFFF_FFFC) == 32'h2000_0000) return 2;
        return 3;
    endfunction

    task automatic send_aw(input logic [31:0] a, input int dly);
        int t;
        t = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        awaddr = a;
        awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!awready) timeout("aw_ready");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int t;
        t = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        @(negedge clk);
        while (!wready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!wready) timeout("w_ready");
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input int dly);
        int t;
        t = 0;
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        araddr = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!arready) timeout("ar_ready");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_b_idle();
        int t;
        t = 0;
        while (b_done != b_issued && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (b_done != b_issued) timeout("b_idle");
    endtask

    task automatic wait_r_idle();
        int t;
        t = 0;
        while (r_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (r_q.size() != 0) timeout("r_idle");
    endtask

    // Apply the write to the model and queue its expected effects
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int rg;
        int wi;
        logic [31:0] v;
        rg = region(a);
        wi = int'(a[31:2]);
        b_q.push_back(rg == 3 ? 2'b11 : 2'b00);
        b_issued++;
        if (rg == 0) begin
            v = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            ref_mem[wi] = v;
        end
        if (rg == 1 && s[0]) con_q.push_back(d[7:0]);
        if (rg == 2 && d == 32'd123456789) ref_pass = 1'b1;
        if (rg == 3) err_exp++;
    endtask

    task automatic model_read(input logic [31:0] a);
        int rg;
        rg = region(a);
        case (rg)
            0: r_q.push_back({2'b00, ref_mem[int'(a[31:2])]});
            1: r_q.push_back({2'b00, 32'h0});
            2: r_q.push_back({2'b00, 31'b0, ref_pass});
            default: begin
                r_q.push_back({2'b11, 32'hDEADBEEF});
                err_exp++;
            end
        endcase
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int ad, input int wd);
        model_write(a, d, s);
        fork
            send_aw(a, ad);
            send_w(d, s, wd);
        join
    endtask

    task automatic do_read(input logic [31:0] a, input int dly);
        wait_b_idle();
        model_read(a);
        send_ar(a, dly);
    endtask

    function automatic logic [31:0] pick_ram();
        logic [31:0] w;
        w = ($urandom_range(0, 9) == 0) ? 32'd4095 : 32'($urandom_range(0, 15));
        return (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] pick_bad();
        case ($urandom_range(0, 2))
            0: return 32'h3000_0000;
            1: return 32'h0000_4000 + 32'($urandom_range(0, 7) * 4);
            default: return 32'h1000_0004;
        endcase
    endfunction

    // Random B/R back-pressure; b_hold forces bready low
    initial begin
        bready = 1'b0;
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bready = !b_hold && ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop expectations on handshakes and check stability while stalled
    initial begin
        logic        b_wait;
        logic        r_wait;
        logic [1:0]  b_prev;
        logic [33:0] r_prev;
        b_wait = 1'b0;
        r_wait = 1'b0;
        b_prev = 2'b00;
        r_prev = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                b_wait = 1'b0;
                r_wait = 1'b0;
            end else begin
                if (b_wait) begin
                    chk("bvalid_stable", bvalid, 1);
                    chk("bresp_stable", bresp, b_prev);
                end
                if (r_wait) begin
                    chk("rvalid_stable", rvalid, 1);
                    chk("rdata_stable", {rresp, rdata}, r_prev);
                end
                if (bvalid && bready) begin
                    if (b_q.size() == 0) timeout("b_unexpected");
                    else chk("bresp", bresp, b_q.pop_front());
                    b_done++;
                end
                if (rvalid && rready) begin
                    if (r_q.size() == 0) timeout("r_unexpected");
                    else chk("rresp_rdata", {rresp, rdata}, r_q.pop_front());
                end
                if (console_valid) begin
                    if (con_q.size() == 0) timeout("console_unexpected");
                    else chk("console_data", console_data, con_q.pop_front());
                end
                if (err_decode) err_seen++;
                b_wait = bvalid && !bready;
                b_prev = bresp;
                r_wait = rvalid && !rready;
                r_prev = {rresp, rdata};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t;
        int e0;
        logic [31:0] a;
        logic [31:0] d;
        resetn = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        awaddr = '0;
        wdata = '0;
        wstrb = '0;
        araddr = '0;
        awprot = '0;
        arprot = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_tests_passed", tests_passed, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
`ifndef AXIL_STALL_EN
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0);
        do_write(32'h0000_3FFC, $urandom, 4'hF, 0, 0);

        // AW leads W by two cycles; B must follow the W handshake directly
        wait_b_idle();
        do_write(32'h10, 32'hA5A5_5A5A, 4'hF, 0, 2);
`ifndef AXIL_STALL_EN
        @(negedge clk);
        chk("b_latency", bvalid, 1);
        @(posedge clk);
        #1;
`endif
        wait_b_idle();
        model_read(32'h10);
        send_ar(32'h10, 0);
`ifndef AXIL_STALL_EN
        @(negedge clk);
        chk("r_latency", rvalid, 1);
        @(posedge clk);
        #1;
`endif
        do_write(32'h10, 32'h1122_3344, 4'b0101, 1, 0);
        do_read(32'h10, 0);

        // Reset with only AW held: nothing may commit afterwards from it
        wait_b_idle();
        wait_r_idle();
        send_aw(32'h30, 0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        ref_pass = 1'b0;
        @(negedge clk);
        chk("mid_rst_bvalid", bvalid, 0);
`ifndef AXIL_STALL_EN
        chk("mid_rst_awready", awready, 1);
`endif
        @(posedge clk);
        #1;
        do_write(32'h34, 32'hCAFE_0034, 4'hF, 0, 1);
        do_read(32'h30, 0);
        do_read(32'h34, 0);

        // Hold bready low; a second write is accepted but answered later
        wait_b_idle();
        b_hold = 1'b1;
        @(posedge clk);
        #1;
        do_write(32'h20, 32'h0BAD_F00D, 4'hF, 0, 0);
        t = 0;
        while (!bvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bvalid) timeout("b_hold_wait");
        repeat (5) @(negedge clk);
        chk("b_hold_valid", bvalid, 1);
        @(posedge clk);
        #1;
        do_write(32'h0000_4000, 32'h1357_9BDF, 4'hF, 1, 0);
        @(negedge clk);
        chk("b_first_resp", {bvalid, bresp}, 3'b100);
        @(posedge clk);
        #1;
        b_hold = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(bvalid && bready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!(bvalid && bready)) timeout("b_release");
        @(negedge clk);
        chk("b_gap", bvalid, 0);
        @(posedge clk);
        #1;

        // Console and test-pass registers
        do_write(32'h1000_0000, 32'h0000_0048, 4'h1, 0, 0);
        do_write(32'h2000_0000, 32'd123456789, 4'h0, 0, 0);
        do_read(32'h2000_0000, 0);
        do_write(32'h2000_0000, 32'd5, 4'hF, 0, 0);
        do_read(32'h2000_0000, 0);
        wait_b_idle();
        chk("tests_passed_sticky", tests_passed, ref_pass);

        // Unmapped read gives one err_decode pulse
        wait_r_idle();
        e0 = err_seen;
        do_read(32'h3000_0000, 0);
        wait_r_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("err_pulse", 32'(err_seen - e0), 1);

`ifndef AXIL_STALL_EN
        // Commit and AR on the same word in one cycle: read sees old data
        wait_b_idle();
        wait_r_idle();
        model_read(32'h8);
        fork
            do_write(32'h8, 32'h7777_8888, 4'hF, 0, 0);
            send_ar(32'h8, 0);
        join
        do_read(32'h8, 0);
`endif

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            d = $urandom;
            if (k < 3) begin
                a = pick_ram();
                do_write(a, d, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (k < 6) begin
                a = pick_ram();
                do_read(a, $urandom_range(0, 2));
            end else if (k == 6) begin
                do_write(32'h1000_0000 | 32'($urandom_range(0, 3)), d, 4'($urandom_range(0, 15)), 0, 1);
            end else if (k == 7) begin
                if ($urandom_range(0, 3) == 0) d = 32'd123456789;
                do_write(32'h2000_0000, d, 4'hF, $urandom_range(0, 2), 0);
                do_read(32'h2000_0000, 0);
            end else if (k == 8) begin
                do_write(pick_bad(), d, 4'hF, 0, $urandom_range(0, 2));
            end else begin
                do_read(pick_bad(), $urandom_range(0, 2));
            end
        end

        wait_b_idle();
        wait_r_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("b_q_empty", 32'(b_q.size()), 0);
        chk("r_q_empty", 32'(r_q.size()), 0);
        chk("con_q_empty", 32'(con_q.size()), 0);
        chk("err_count", 32'(err_seen), 32'(err_exp));
        chk("tests_passed_end", tests_passed, ref_pass);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
